// File: rtl/network.sv
// Spiking core: 4 binary inputs fully connected to 2 LIF neurons, n_cycles timesteps per run (NETWORK_LEAK_EN enables leak).
// Latency: 2 cycles per timestep (SAMPLE, UPDATE); ready is low for 2*n_cycles cycles per run when samples arrive on time.
// Backpressure: sample stays high and all state freezes while sample_ready is low; start is accepted only while ready is high.
module network #(
    parameter int n_cycles            = 10,
    parameter int cycles_cnt_bitwidth = 5,
    parameter int MEM_BW              = 12,
    parameter int THRESHOLD           = 16,
    parameter int LEAK_SHIFT          = 3,
    parameter logic signed [7:0] W0 [0:3] = '{8'sd5, 8'sd5, 8'sd5, 8'sd5},
    parameter logic signed [7:0] W1 [0:3] = '{8'sd8, 8'sd8, -8'sd4, -8'sd4}
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sample_ready,
    output logic       ready,
    output logic       sample,
    input  logic [3:0] in_spikes,
    output logic [1:0] out_spikes
);

    localparam int SW = MEM_BW + 2;
    localparam logic signed [SW-1:0]     VMAX = SW'((2 ** (MEM_BW - 1)) - 1);
    localparam logic signed [MEM_BW-1:0] THR  = MEM_BW'(THRESHOLD);
    localparam logic [cycles_cnt_bitwidth-1:0] LAST = cycles_cnt_bitwidth'(n_cycles - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t                         state;
    logic [cycles_cnt_bitwidth-1:0] cnt;
    logic [3:0]                     spikes_q;
    logic signed [MEM_BW-1:0]       v0, v1;

    logic signed [SW-1:0]     acc0, acc1;
    logic signed [MEM_BW-1:0] nv0, nv1;
    logic                     fire0, fire1;

    // Membranes never go negative, so the upper clamp is the only saturation besides the floor at 0.
    function automatic logic signed [MEM_BW-1:0] clamp(input logic signed [SW-1:0] a);
        if (a[SW-1])
            return '0;
        else if (a > VMAX)
            return VMAX[MEM_BW-1:0];
        else
            return a[MEM_BW-1:0];
    endfunction

    always_comb begin
        acc0 = SW'(v0);
        acc1 = SW'(v1);
`ifdef NETWORK_LEAK_EN
        acc0 = acc0 - (acc0 >>> LEAK_SHIFT);
        acc1 = acc1 - (acc1 >>> LEAK_SHIFT);
`endif
        for (int i = 0; i < 4; i++) begin
            if (spikes_q[i]) begin
                acc0 = acc0 + SW'(W0[i]);
                acc1 = acc1 + SW'(W1[i]);
            end
        end
        nv0   = clamp(acc0);
        nv1   = clamp(acc1);
        fire0 = (nv0 >= THR);
        fire1 = (nv1 >= THR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready      <= 1'b0;
            sample     <= 1'b0;
            out_spikes <= 2'b00;
            cnt        <= '0;
            spikes_q   <= '0;
            v0         <= '0;
            v1         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (start && ready) begin
                        v0         <= '0;
                        v1         <= '0;
                        out_spikes <= 2'b00;
                        cnt        <= '0;
                        ready      <= 1'b0;
                        sample     <= 1'b1;
                        state      <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (sample_ready) begin
                        spikes_q <= in_spikes;
                        sample   <= 1'b0;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    out_spikes <= {fire1, fire0};
                    v0         <= fire0 ? '0 : nv0;
                    v1         <= fire1 ? '0 : nv1;
                    if (cnt == LAST) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        sample <= 1'b1;
                        state  <= SAMPLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_network.sv
// Directed bench for network: reset, full activity, stall, inhibition, back-to-back runs, reset mid-run.
module tb_network;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sample_ready;
    logic       ready;
    logic       sample;
    logic [3:0] in_spikes;
    logic [1:0] out_spikes;

    int errors = 0;
    int checks = 0;

    network dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sample_ready(sample_ready),
        .ready       (ready),
        .sample      (sample),
        .in_spikes   (in_spikes),
        .out_spikes  (out_spikes)
    );

    always #5 clk = ~clk;

    // Neuron 1 under full activity: 8 per step; with leak it fires every 3rd step, without every 2nd.
`ifdef NETWORK_LEAK_EN
    localparam logic [9:0] FULL_N1 = 10'h124;
`else
    localparam logic [9:0] FULL_N1 = 10'h2AA;
`endif
    localparam logic [9:0] FULL_N0 = 10'h3FF;
    localparam logic [9:0] INH_N0  = 10'h2AA;
    localparam logic [9:0] INH_N1  = 10'h000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] pat, input logic [9:0] e0,
                       input logic [9:0] e1, input int stall_at, input bit keep_start);
        logic [1:0] prev;
        in_spikes    = pat;
        sample_ready = 1'b1;
        start        = 1'b1;
        step();
        chk(tag, "start_ready", {1'b0, ready}, 2'd0);
        chk(tag, "start_sample", {1'b0, sample}, 2'd1);
        chk(tag, "start_out", out_spikes, 2'b00);
        if (!keep_start) start = 1'b0;
        prev = 2'b00;
        for (int t = 0; t < 10; t++) begin
            if (t == stall_at) begin
                sample_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    step();
                    chk(tag, "stall_sample", {1'b0, sample}, 2'd1);
                    chk(tag, "stall_ready", {1'b0, ready}, 2'd0);
                    chk(tag, "stall_out", out_spikes, prev);
                end
                sample_ready = 1'b1;
            end
            step();
            chk(tag, "cap_sample", {1'b0, sample}, 2'd0);
            chk(tag, "cap_ready", {1'b0, ready}, 2'd0);
            chk(tag, "cap_out_hold", out_spikes, prev);
            step();
            prev = {e1[t], e0[t]};
            chk(tag, "upd_out", out_spikes, prev);
            chk(tag, "upd_ready", {1'b0, ready}, {1'b0, t == 9});
            chk(tag, "upd_sample", {1'b0, sample}, {1'b0, t != 9});
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        sample_ready = 1'b0;
        in_spikes    = 4'h0;

        step();
        chk("reset", "ready", {1'b0, ready}, 2'd0);
        chk("reset", "sample", {1'b0, sample}, 2'd0);
        chk("reset", "out", out_spikes, 2'b00);
        rst_n = 1'b1;
        step();
        chk("idle", "ready", {1'b0, ready}, 2'd1);
        chk("idle", "sample", {1'b0, sample}, 2'd0);
        chk("idle", "out", out_spikes, 2'b00);

        run("full", 4'hF, FULL_N0, FULL_N1, -1, 1'b0);
        step();
        chk("full_idle", "ready", {1'b0, ready}, 2'd1);
        chk("full_idle", "sample", {1'b0, sample}, 2'd0);

        run("stall", 4'hF, FULL_N0, FULL_N1, 2, 1'b0);
        step();

        run("inhib", 4'b1100, INH_N0, INH_N1, -1, 1'b0);
        step();

        run("b2b_a", 4'hF, FULL_N0, FULL_N1, -1, 1'b1);
        run("b2b_b", 4'hF, FULL_N0, FULL_N1, -1, 1'b0);
        step();
        chk("b2b_idle", "ready", {1'b0, ready}, 2'd1);
        chk("b2b_idle", "sample", {1'b0, sample}, 2'd0);

        // Abort during the UPDATE of timestep 1, after timestep 0 produced a spike on neuron 0.
        in_spikes    = 4'hF;
        sample_ready = 1'b1;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("midrst", "t0_out", out_spikes, 2'b01);
        step();
        rst_n = 1'b0;
        step();
        chk("midrst", "ready", {1'b0, ready}, 2'd0);
        chk("midrst", "sample", {1'b0, sample}, 2'd0);
        chk("midrst", "out", out_spikes, 2'b00);
        rst_n = 1'b1;
        step();
        chk("midrst_rel", "ready", {1'b0, ready}, 2'd1);
        chk("midrst_rel", "sample", {1'b0, sample}, 2'd0);
        chk("midrst_rel", "out", out_spikes, 2'b00);

        run("post_rst", 4'hF, FULL_N0, FULL_N1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
